// File: rtl/demux_sched_pkg.sv
// Shared definitions for the demux round-robin scheduler: output count, selector
// width, mode encoding, slot state encoding and the circular priority search.
package demux_sched_pkg;

  localparam int unsigned N_OUT  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DROP_W = 8;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // First enabled output at or after ptr, wrapping modulo N_OUT; returns ptr if none.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_OUT-1:0] mask,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      idx = SEL_W'(ptr + SEL_W'(k));
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_1to8_onehot.sv
// 1:8 one-hot demultiplexer: drives bit sel of out with in, all other bits zero.
//   in  : 1-bit value to route
//   sel : output index
//   out : one-hot (or zero) result
module demux_1to8_onehot
  import demux_sched_pkg::*;
(
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] out
);

  assign out = in ? (N_OUT'(1) << sel) : '0;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Single-slot scheduler steering one valid/ready beat stream onto 8 outputs,
// either round-robin over enabled outputs (BURST beats each) or by in_dest.
//   clk, rst             : clock, async active-high reset
//   mode                 : 0 round-robin, 1 address-directed (per accepted beat)
//   en_mask              : per-output enable
//   in_valid/in_ready    : upstream handshake, in_data/in_dest payload
//   out_valid/out_ready  : per-output handshake, out_data shared payload
//   sel                  : index of the output held in the slot
//   drop_cnt             : saturating count of address-mode beats to disabled outputs
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N_OUT-1:0] en_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_dest,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [N_OUT-1:0] out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  slot_state_t       state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic             drain;
  logic             accept;
  logic [SEL_W-1:0] rr_t;

  // Handshake: the slot can take a beat if empty or emptying this cycle.
  assign drain    = (state_q == FULL) && out_ready[sel_q];
  assign in_ready = ((state_q == EMPTY) || drain) && ((mode == MODE_ADDR) || (en_mask != '0));
  assign accept   = in_valid && in_ready;
  assign rr_t     = rr_pick(en_mask, ptr_q);

  // State register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: drain empties the slot, a non-dropped accept (re)fills it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    if (drain) state_d = EMPTY;

    if (accept) begin
      if (mode == MODE_RR) begin
        state_d = FULL;
        data_d  = in_data;
        sel_d   = rr_t;
        // Pointer parks on the current target until its burst completes.
        if (cnt_q == CNT_LAST) begin
          ptr_d = SEL_W'(rr_t + SEL_W'(1));
          cnt_d = '0;
        end else begin
          ptr_d = rr_t;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (en_mask[in_dest]) begin
        state_d = FULL;
        data_d  = in_data;
        sel_d   = in_dest;
      end else if (drop_q != DROP_MAX) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  demux_1to8_onehot u_onehot (
    .in  (state_q == FULL),
    .sel (sel_q),
    .out (out_valid)
  );

  assign out_data = data_q;
  assign sel      = sel_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
module tb_demux_rr_scheduler;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode;
  logic [7:0] en_mask;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [2:0] sel;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  demux_rr_scheduler #(.WIDTH(8), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot holding at most one beat plus the round-robin position.
  int         m_full, m_sel, m_ptr, m_cnt, m_drop, m_t;
  logic [7:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_drop = 0; m_data = 8'h00;
    end else begin
      int drn, rdy;
      drn = (m_full != 0) && out_ready[m_sel];
      rdy = ((m_full == 0) || drn) && (mode || (en_mask != 8'h00));
      if (drn) m_full = 0;
      if (in_valid && rdy) begin
        if (!mode) begin
          m_t = -1;
          for (int k = 0; k < 8; k++)
            if (m_t < 0 && en_mask[(m_ptr + k) % 8]) m_t = (m_ptr + k) % 8;
          m_full = 1; m_data = in_data; m_sel = m_t;
          m_cnt = m_cnt + 1;
          if (m_cnt == BURST) begin
            m_cnt = 0;
            m_ptr = (m_t + 1) % 8;
          end else begin
            m_ptr = m_t;
          end
        end else if (en_mask[in_dest]) begin
          m_full = 1; m_data = in_data; m_sel = in_dest;
        end else if (m_drop < 255) begin
          m_drop = m_drop + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started && !rst) begin
      logic [7:0] ev;
      int         er;
      ev = (m_full != 0) ? (8'h01 << m_sel) : 8'h00;
      er = ((m_full == 0) || ((m_full != 0) && out_ready[m_sel])) && (mode || (en_mask != 8'h00));
      chk("cyc_out_valid", 32'(out_valid), 32'(ev));
      chk("cyc_sel", 32'(sel), 32'(m_sel));
      chk("cyc_in_ready", 32'(in_ready), 32'(er));
      chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_full != 0) chk("cyc_out_data", 32'(out_data), 32'(m_data));
    end
  end

  // Offer one beat until accepted (bounded); optionally pin the resulting slot contents.
  task automatic send(input string name, input logic m, input logic [2:0] d,
                      input logic [7:0] dat, input int exp_sel, output int waited);
    logic [7:0] ev;
    mode = m; in_dest = d; in_data = dat; in_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (exp_sel >= 0) begin
        ev = 8'h01 << exp_sel;
        chk({name, "_sel"}, 32'(sel), 32'(exp_sel));
        chk({name, "_out_valid"}, 32'(out_valid), 32'(ev));
        chk({name, "_out_data"}, 32'(out_data), 32'(dat));
      end
    end
  endtask

  initial begin
    int w;
    mode = 1'b0; en_mask = 8'h00; in_valid = 1'b0; in_data = 8'h00; in_dest = 3'd0;
    out_ready = 8'hFF;
    #1 rst = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1;

    // 1: full-mask round robin, 4 beats per output, back to back.
    en_mask = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      send("t1", 1'b0, 3'd0, 8'(i + 8'h10), i / 4, w);
      chk("t1_no_stall", 32'(w), 32'd0);
    end
    send("t1_wrap", 1'b0, 3'd0, 8'hEE, 0, w);
    repeat (3) begin send("t1_tail", 1'b0, 3'd0, 8'hEF, 0, w); end

    // 2: sparse mask alternates 2 and 5.
    en_mask = 8'h24;
    for (int i = 0; i < 16; i++)
      send("t2", 1'b0, 3'd0, 8'(8'h40 + i), ((i / 4) % 2) ? 5 : 2, w);
    out_ready = 8'h00;
    en_mask = 8'h00; in_valid = 1'b1; mode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_mask0_ready", 32'(in_ready), 32'd0);
      chk("t2_mask0_valid", 32'(out_valid), 32'h20);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 8'hFF; en_mask = 8'hFF;
    @(posedge clk); #1;

    // 4: stall on out1 then drain and accept together.
    out_ready = 8'h00;
    send("t4_load", 1'b1, 3'd1, 8'hA5, 1, w);
    mode = 1'b1; in_dest = 3'd4; in_data = 8'h5A; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(out_valid), 32'h02);
      chk("t4_hold_data", 32'(out_data), 32'hA5);
      chk("t4_hold_sel", 32'(sel), 32'd1);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 8'h02;
    @(negedge clk);
    chk("t4_drain_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 8'hFF;
    chk("t4_new_valid", 32'(out_valid), 32'h10);
    chk("t4_new_data", 32'(out_data), 32'h5A);

    // 6: RR burst interrupted by address-mode beats resumes on out3.
    rst = 1'b1; #2 rst = 1'b0;
    @(posedge clk); #1;
    en_mask = 8'h08;
    send("t6_rr_a", 1'b0, 3'd0, 8'h31, 3, w);
    send("t6_rr_b", 1'b0, 3'd0, 8'h32, 3, w);
    en_mask = 8'hFF;
    send("t6_addr1", 1'b1, 3'd1, 8'hA1, 1, w);
    send("t6_addr6", 1'b1, 3'd6, 8'hA6, 6, w);
    send("t6_addr3", 1'b1, 3'd3, 8'hA3, 3, w);
    send("t6_rr_c", 1'b0, 3'd0, 8'h33, 3, w);
    send("t6_rr_d", 1'b0, 3'd0, 8'h34, 3, w);
    send("t6_rr_e", 1'b0, 3'd0, 8'h41, 4, w);

    // 3: address mode delivery, drop, saturation.
    send("t3_dest6", 1'b1, 3'd6, 8'h66, 6, w);
    en_mask = 8'hF7;
    send("t3_drop", 1'b1, 3'd3, 8'h77, -1, w);
    chk("t3_drop_valid", 32'(out_valid), 32'h0);
    chk("t3_drop_one", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 299; i++) send("t3_sat", 1'b1, 3'd3, 8'(i), -1, w);
    chk("t3_drop_sat", 32'(drop_cnt), 32'd255);
    en_mask = 8'hFF;

    // 5: asynchronous reset while a beat is held.
    out_ready = 8'h00;
    send("t5_load", 1'b0, 3'd0, 8'h55, 4, w);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 8'hFF;
    for (int i = 0; i < 5; i++) send("t5_after", 1'b0, 3'd0, 8'(8'h90 + i), (i < 4) ? 0 : 1, w);

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      mode      = 1'($urandom);
      en_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_dest   = 3'($urandom);
      in_data   = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      if (c == 1500) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
